seg_debug_display: RTL and testbench
====================================

Name: seg_debug_display

Overview:
- Parametrised debug display engine for the single-cycle CPU board build.
- Time-multiplexes one of NUM_CH 32-bit-class debug channels (PC, instruction, register-file port, memory port, ...) onto a common-anode seven-segment bank of NUM_DIGITS digits.
- Snapshots the selected channel once per scan frame, so a displayed value is never torn.
- Provides a debounced single-step pulse for the CPU clock enable.

Parameters:
- NUM_DIGITS, 8: digits in the bank; each displays one 4-bit nibble.
- NUM_CH, 4: number of selectable data channels.
- SCAN_DIV, 50000: clk cycles per digit slot; must be >= 2.
- DEBOUNCE_CYC, 20000: clk cycles the synchronised button must stay stable before it is accepted; must be >= 2.
- SEL_W, $clog2(NUM_CH) (minimum 1): width of ch_sel.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- btn_step  in  1  raw step push-button; asynchronous, bouncy.
- ch_sel  in  SEL_W  channel select.
- ch_data  in  NUM_CH*NUM_DIGITS*4  packed channels; channel k occupies bits [k*NUM_DIGITS*4 +: NUM_DIGITS*4]; digit 0 is the least significant nibble.
- step_pulse  out  1  one-cycle pulse per accepted button press.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.
- seg_n  out  8  segments, active-low; bit0=a ... bit6=g, bit7=dp.
- dig_n  out  NUM_DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
- Reset (asynchronous, immediate):
  - Counters: scan_cnt=0, digit index idx=NUM_DIGITS-1.
  - Snapshot register and latched channel are cleared to 0.
  - Debounce state: sync FFs=0, stable=0, deb_cnt=0.
  - Outputs: step_pulse=0, frame_start=0, seg_n=8'hFF, dig_n=all ones (display blank).
- Scan divider:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted in the cycle where scan_cnt==SCAN_DIV-1.
  - On tick, idx advances, wrapping NUM_DIGITS-1 -> 0.
- Frame snapshot: on the tick where idx wraps to 0:
  - ch_sel is latched into sel_q and the selected channel is copied into snap.
  - frame_start pulses in that same cycle (the first frame_start occurs after SCAN_DIV clocks following reset).
  - ch_sel / ch_data changes mid-frame have no effect until the next wrap.
- Output register: seg_n and dig_n are registered.
  - They reflect the new idx on the clock edge after the tick (latency 1).
  - dig_n[idx]=0; all other bits are 1.
- Font (hex, dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Decimal point: seg_n[7]=0 on the digit whose index equals sel_q (a channel indicator). If sel_q >= NUM_DIGITS, dp is never lit.
- Out-of-range select: if sel_q >= NUM_CH, every digit shows "-" (seg_n=8'hBF), with the dp rule still applied.
- Debouncer:
  - btn_step passes through a 2-FF synchroniser to give bs.
  - If bs != stable, deb_cnt increments; otherwise deb_cnt clears.
  - When deb_cnt==DEBOUNCE_CYC-1 with bs still != stable: stable<=bs and deb_cnt clears.
  - step_pulse=1 for exactly one cycle on each 0->1 transition of stable. Release generates no pulse.
  - A bounce shorter than DEBOUNCE_CYC cycles is rejected completely.
- Reset mid-operation: all state is cleared immediately and the display blanks. No step_pulse is generated on reset release, even if the button is held; the held press produces one pulse after the debounce time.

Optional Feature:
- Macro: SEG_DEBUG_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - For the current snapshot, any digit whose index is above the most-significant nonzero nibble is driven seg_n=8'hFF, except that its dp still follows the dp rule.
  - Digit 0 is always shown, so an all-zero value displays a single "0".
  - Blanking does not apply in the out-of-range "-" mode.
- Undefined: all digits are always shown, including leading zeros.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8, NUM_DIGITS=8, NUM_CH=4):
- Reset, ch_sel=1, ch1=32'h89ABCDEF -> seg_n=FF and dig_n=FF until the first tick.
  - First frame_start occurs at cycle 4; one cycle later dig_n=FE, seg_n=8E ("F").
  - Subsequent digits follow every 4 cycles: digit1 = 7'h06 plus dp lit ("E.", 0x06), then digit7=80 ("8").
- Change ch_sel from 1 to 2 mid-frame -> the displayed digits keep channel 1 until the next idx wrap, then switch; frame_start pulses exactly once per 32 cycles.
- ch_sel=3 with NUM_CH=3 -> all digits seg_n=BF; dig_n scans FE, FD, ... 7F and wraps.
- btn_step held high 20 cycles -> exactly one step_pulse, 2+8 cycles after the press (±1). Bounces of 5 cycles high / 5 low -> no pulse.
- Assert resetn low while idx=5 with the button held -> outputs go FF/FF immediately; after release, one pulse follows ~10 cycles later.
- With SEG_DEBUG_LZ_BLANK_EN, ch0=32'h0000_00A0, sel=0:
  - digits 2-7 read seg_n=FF (except digit0's dp).
  - digit1=88 ("A"), digit0=40 ("0.").
  - Without the macro, digits 2-7 read C0.

Source files
------------

// File: rtl/seg_debug_display.sv
// seg_debug_display: multiplexed seven-segment debug display with frame snapshot and debounced step button
// Ports: clk, resetn (async, active-low); btn_step raw button; ch_sel/ch_data channel select and packed channels;
//        step_pulse one cycle per accepted press; frame_start pulses when a snapshot is taken;
//        seg_n active-low segments (bit7 = dp); dig_n active-low one-hot digit enables.
// Option: define SEG_DEBUG_LZ_BLANK_EN to blank leading zeros of the displayed value.
module seg_debug_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_CH       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int SEL_W        = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       btn_step,
  input  logic [SEL_W-1:0]           ch_sel,
  input  logic [NUM_CH*NUM_DIGITS*4-1:0] ch_data,
  output logic                       step_pulse,
  output logic                       frame_start,
  output logic [7:0]                 seg_n,
  output logic [NUM_DIGITS-1:0]      dig_n
);
  localparam int DW = NUM_DIGITS * 4;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYC);
  localparam logic [127:0] FONT = 128'h8E86A1C6_83889080_F8829299_B0A4F9C0;
  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] idx, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0] snap, snap_d, pick;
  logic tick, wrap, oor, dp, blank;
  logic [3:0] nib;
  logic [7:0] seg_d;
  logic s1, bs, stable, accept;
  logic [BW-1:0] deb_cnt;
  assign tick = scan_cnt == CW'(SCAN_DIV - 1);
  assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
  assign frame_start = wrap;
  // Display data is computed from the post-tick state so the registered
  // outputs show the fresh snapshot one edge after the wrap tick.
  always_comb begin
    pick = '0;
    for (int k = 0; k < NUM_CH; k++) pick = ch_sel == SEL_W'(k) ? ch_data[k*DW +: DW] : pick;
    idx_d = wrap ? '0 : idx + IW'(1);
    sel_d = wrap ? ch_sel : sel_q;
    snap_d = wrap ? pick : snap;
    nib = snap_d[idx_d*4 +: 4];
    oor = int'(sel_d) >= NUM_CH;
    dp = int'(sel_d) == int'(idx_d);
    seg_d = {~dp, oor ? 7'h3F : blank ? 7'h7F : FONT[nib*8 +: 7]};
  end
`ifdef SEG_DEBUG_LZ_BLANK_EN
  int msd;
  always_comb begin
    msd = 0;
    for (int i = 1; i < NUM_DIGITS; i++) msd = snap_d[i*4 +: 4] != 4'h0 ? i : msd;
    blank = !oor && int'(idx_d) > msd;
  end
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt <= '0;
      idx <= IW'(NUM_DIGITS - 1);
      sel_q <= '0;
      snap <= '0;
      seg_n <= 8'hFF;
      dig_n <= '1;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + CW'(1);
      if (tick) begin
        idx <= idx_d;
        sel_q <= sel_d;
        snap <= snap_d;
        seg_n <= seg_d;
        dig_n <= ~(NUM_DIGITS'(1) << idx_d);
      end
    end
  end
  assign accept = bs != stable && deb_cnt == BW'(DEBOUNCE_CYC - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      bs <= 1'b0;
      stable <= 1'b0;
      deb_cnt <= '0;
      step_pulse <= 1'b0;
    end else begin
      s1 <= btn_step;
      bs <= s1;
      deb_cnt <= (bs == stable || accept) ? '0 : deb_cnt + BW'(1);
      stable <= accept ? bs : stable;
      step_pulse <= accept && bs;
    end
  end
endmodule

// File: tb/tb_seg_debug_display.sv
// tb_seg_debug_display: randomized scoreboard bench for seg_debug_display
module tb_seg_debug_display;
  localparam int ND = 8, NCH = 3, SD = 4, DC = 8, SW = 2;
  localparam int FRAME = SD * ND;
`ifdef SEG_DEBUG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  logic clk = 1'b0, resetn, btn_step;
  logic [SW-1:0] ch_sel;
  logic [NCH*ND*4-1:0] ch_data;
  logic step_pulse, frame_start;
  logic [7:0] seg_n;
  logic [ND-1:0] dig_n;
  int checks = 0, errors = 0, cyc;
  logic [15:0] disp_q[$];
  int fs_q[$], sp_q[$];
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  seg_debug_display #(.NUM_DIGITS(ND), .NUM_CH(NCH), .SCAN_DIV(SD), .DEBOUNCE_CYC(DC), .SEL_W(SW)) dut (
    .clk(clk), .resetn(resetn), .btn_step(btn_step), .ch_sel(ch_sel), .ch_data(ch_data),
    .step_pulse(step_pulse), .frame_start(frame_start), .seg_n(seg_n), .dig_n(dig_n));
  always #5 clk = ~clk;
  always @(posedge clk or negedge resetn) cyc <= !resetn ? 0 : cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_seg(input logic [31:0] v, input int sel, input int d);
    logic [31:0] rest;
    logic [6:0] g;
    rest = v >> (4 * d);
    if (sel >= NCH) g = 7'h3F;
    else if (LZ && d > 0 && rest == 0) g = 7'h7F;
    else g = font[rest[3:0]][6:0];
    return {sel != d, g};
  endfunction
  task automatic step();
    int sel;
    logic [31:0] v;
    if (cyc % FRAME == SD - 1) begin
      sel = int'(ch_sel);
      v = sel < NCH ? ch_data[sel*32 +: 32] : 32'h0;
      fs_q.push_back(cyc);
      for (int d = 0; d < ND; d++) disp_q.push_back({~(8'd1 << d), exp_seg(v, sel, d)});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rnd_data();
    for (int k = 0; k < NCH; k++) ch_data[k*32 +: 32] = $urandom >> $urandom_range(0, 31);
  endtask
  initial begin
    logic [7:0] prev;
    logic [15:0] e;
    prev = 8'hFF;
    forever begin
      @(negedge clk);
      if (dig_n !== prev) begin
        if (disp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL disp_extra: got dig %h seg %h expected no change", dig_n, seg_n);
        end else begin
          e = disp_q.pop_front();
          chk("disp_dig", 32'(dig_n), 32'(e[15:8]));
          chk("disp_seg", 32'(seg_n), 32'(e[7:0]));
        end
        prev = dig_n;
      end
      if (frame_start === 1'b1) begin
        if (fs_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_extra: got pulse at cycle %0d expected none", cyc);
        end else chk("frame_cyc", cyc, fs_q.pop_front());
      end
      if (step_pulse === 1'b1) begin
        if (sp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL step_extra: got pulse at cycle %0d expected none", cyc);
        end else chk("step_cyc", cyc, sp_q.pop_front());
      end
    end
  end
  initial begin
    resetn = 1'b1;
    btn_step = 1'b0;
    ch_sel = 2'd1;
    rnd_data();
    ch_data[63:32] = 32'h89ABCDEF;
    #1 resetn = 1'b0;
    #1;
    chk("rst_seg", 32'(seg_n), 32'hFF);
    chk("rst_dig", 32'(dig_n), 32'hFF);
    chk("rst_step", 32'(step_pulse), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3 * FRAME) step();
    repeat (13) step();
    ch_sel = 2'd2;
    repeat (2 * FRAME) step();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ch_sel = SW'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) rnd_data();
      step();
    end
    ch_sel = 2'd3;
    repeat (2 * FRAME) step();
    ch_sel = 2'd0;
    ch_data[31:0] = 32'h0000_00A0;
    repeat (2 * FRAME) step();
    btn_step = 1'b1;
    sp_q.push_back(cyc + DC + 2);
    repeat (20) step();
    btn_step = 1'b0;
    repeat (20) step();
    repeat (4) begin
      btn_step = 1'b1;
      repeat (5) step();
      btn_step = 1'b0;
      repeat (5) step();
    end
    repeat (20) step();
    for (int i = 0; i < 2 * FRAME && cyc % FRAME != 22; i++) step();
    btn_step = 1'b1;
    repeat (3) step();
    resetn = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg_n), 32'hFF);
    chk("midrst_dig", 32'(dig_n), 32'hFF);
    chk("midrst_step", 32'(step_pulse), 32'h0);
    disp_q.delete();
    fs_q.delete();
    sp_q.delete();
    disp_q.push_back(16'hFFFF);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    sp_q.push_back(cyc + DC + 2);
    repeat (40) step();
    btn_step = 1'b0;
    repeat (20) step();
    for (int i = 0; i < 2 * FRAME && disp_q.size() != 0; i++) begin
      step();
      @(negedge clk);
      #1;
    end
    chk("disp_left", disp_q.size(), 0);
    chk("fs_left", fs_q.size(), 0);
    chk("sp_left", sp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
